// File: rtl/chip8_keypad_scan.sv
// 4x4 CHIP-8 hex keypad scanner: per-key debounce, with keys_out indexed by hex value and a key-press event.
// Latency: keys_out and key_code change on the UPDATE edge. A scan period is 4*(SETTLE_CYCLES+1)+1 clocks.
// No backpressure. Optional ghost rejection is enabled with `define KEYPAD_GHOST_REJECT_EN.
module chip8_keypad_scan #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [15:0] keys_out,
    output logic        key_event,
    output logic [3:0]  key_code
);

    typedef enum logic [1:0] {SETTLE, SAMPLE, UPDATE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] DEB_LAST    = 4'(DEBOUNCE_SCANS - 1);

    state_t      state, state_nxt;
    logic [7:0]  settle_cnt;
    logic [1:0]  row_idx;
    logic [3:0]  col_meta, col_sync;
    logic [15:0] raw;
    logic [15:0] raw_hex;
    logic [3:0]  deb_cnt     [16];
    logic [3:0]  deb_cnt_nxt [16];
    logic [15:0] stable_nxt;
    logic [15:0] new_press;
    logic [3:0]  press_code;
    logic        ghost;

    // raw is stored in matrix order (row*4+col); re-order it into hex order.
    assign raw_hex = {raw[15], raw[11], raw[7], raw[3], raw[14], raw[12], raw[10], raw[9],
                      raw[8],  raw[6],  raw[5], raw[4], raw[2],  raw[1],  raw[0],  raw[13]};

`ifdef KEYPAD_GHOST_REJECT_EN
    assign ghost = ($countones(raw) >= 3);
`else
    assign ghost = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_meta <= '0;
            col_sync <= '0;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= SETTLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (row_idx == 2'd3) ? UPDATE : SETTLE;
            UPDATE:  state_nxt = SETTLE;
            default: state_nxt = SETTLE;
        endcase
    end

    // The async reset gates the row drive so the matrix is idle while held in reset.
    always_comb begin
        row_out = 4'b1111;
        if (reset && (state != UPDATE)) row_out = ~(4'b0001 << row_idx);
    end

    always_comb begin
        stable_nxt = keys_out;
        for (int n = 0; n < 16; n++) begin
            deb_cnt_nxt[n] = deb_cnt[n];
            if (raw_hex[n] == keys_out[n]) begin
                deb_cnt_nxt[n] = 4'd0;
            end else if (deb_cnt[n] == DEB_LAST) begin
                stable_nxt[n]  = ~keys_out[n];
                deb_cnt_nxt[n] = 4'd0;
            end else begin
                deb_cnt_nxt[n] = deb_cnt[n] + 4'd1;
            end
        end
    end

    assign new_press = stable_nxt & ~keys_out;

    always_comb begin
        press_code = 4'd0;
        for (int n = 15; n >= 0; n--) begin
            if (new_press[n]) press_code = 4'(n);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_cnt <= '0;
            row_idx    <= '0;
            raw        <= '0;
            keys_out   <= '0;
            key_event  <= 1'b0;
            key_code   <= '0;
            for (int n = 0; n < 16; n++) deb_cnt[n] <= '0;
        end else begin
            key_event <= 1'b0;
            case (state)
                SETTLE: settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
                SAMPLE: begin
                    raw[{row_idx, 2'b00} +: 4] <= ~col_sync;
                    // Wraps 3 -> 0 so the row index is already back at row 0 for UPDATE.
                    row_idx <= row_idx + 2'd1;
                end
                UPDATE: begin
                    if (!ghost) begin
                        for (int n = 0; n < 16; n++) deb_cnt[n] <= deb_cnt_nxt[n];
                        keys_out  <= stable_nxt;
                        key_event <= |new_press;
                        if (|new_press) key_code <= press_code;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_keypad_scan.sv
// Bench for chip8_keypad_scan: emulates the key matrix and checks every cycle against a scan-level model.
module tb_chip8_keypad_scan;

    localparam int S      = 16;
    localparam int D      = 4;
    localparam int PERIOD = 4 * (S + 1) + 1;
    // Hex value at matrix position row*4+col, one nibble per position.
    localparam logic [63:0] LAYOUT = 64'hFB0AE987D654C321;

    logic        clock;
    logic        reset;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys_out;
    logic        key_event;
    logic [3:0]  key_code;

    logic [15:0] keys;
    logic [15:0] scan_pat;
    logic [15:0] m_stable;
    logic        m_evt;
    logic [3:0]  m_code;
    logic [15:0] hist [$];
    int          k;
    int          checks;
    int          errors;

    chip8_keypad_scan #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .col_in   (col_in),
        .row_out  (row_out),
        .keys_out (keys_out),
        .key_event(key_event),
        .key_code (key_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[LAYOUT[(r * 4 + c) * 4 +: 4]]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_evt    = 1'b0;
        m_code   = '0;
        hist.delete();
    endtask

    // A key flips once its last D accepted scans all disagree with its stable value.
    task automatic model_update();
        logic [15:0] nxt;
        logic [15:0] rises;
        logic        flip;
        logic        discard;
        discard = 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
        discard = ($countones(scan_pat) >= 3);
`endif
        m_evt = 1'b0;
        if (!discard) begin
            hist.push_back(scan_pat);
            nxt = m_stable;
            for (int n = 0; n < 16; n++) begin
                flip = (hist.size() >= D);
                if (flip) begin
                    for (int j = hist.size() - D; j < hist.size(); j++) begin
                        if (hist[j][n] == m_stable[n]) flip = 1'b0;
                    end
                end
                if (flip) nxt[n] = ~m_stable[n];
            end
            rises = nxt & ~m_stable;
            if (rises != 16'h0) begin
                m_evt = 1'b1;
                for (int n = 15; n >= 0; n--) if (rises[n]) m_code = 4'(n);
            end
            m_stable = nxt;
        end
    endtask

    task automatic tick();
        int p;
        logic [3:0] exp_row;
        @(negedge clock);
        k++;
        p = k % PERIOD;
        if (p == 0) model_update();
        else        m_evt = 1'b0;
        exp_row = 4'hF;
        if (p != PERIOD - 1) exp_row[p / (S + 1)] = 1'b0;
        chk("row_out",   32'(row_out),   32'(exp_row));
        chk("keys_out",  32'(keys_out),  32'(m_stable));
        chk("key_event", 32'(key_event), 32'(m_evt));
        chk("key_code",  32'(key_code),  32'(m_code));
    endtask

    task automatic run_scan(input logic [15:0] pat);
        keys     = pat;
        scan_pat = pat;
        repeat (PERIOD) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"},  32'(row_out),   32'h0000000F);
        chk({tag, "_keys"}, 32'(keys_out),  32'h00000000);
        chk({tag, "_evt"},  32'(key_event), 32'h00000000);
        chk({tag, "_code"}, 32'(key_code),  32'h00000000);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        k = 0;
        model_reset();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        k        = 0;
        keys     = '0;
        scan_pat = '0;
        reset    = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        chk_reset_vals("por");
        release_reset();

        run_scan(16'h0000);
        run_scan(16'h0000);
        chk("idle_keys", 32'(keys_out), 32'h0);

        repeat (4) run_scan(16'h0040);
        chk("press6_keys", 32'(keys_out),  32'h0040);
        chk("press6_evt",  32'(key_event), 32'h1);
        chk("press6_code", 32'(key_code),  32'h6);
        run_scan(16'h0040);

        repeat (4) run_scan(16'h0000);
        chk("release6_keys", 32'(keys_out), 32'h0);

        for (int i = 0; i < 8; i++) run_scan((i % 2 == 0) ? 16'h0040 : 16'h0000);
        chk("bounce_keys", 32'(keys_out), 32'h0);

        repeat (4) run_scan(16'h8001);
        chk("pair_keys", 32'(keys_out),  32'h8001);
        chk("pair_evt",  32'(key_event), 32'h1);
        chk("pair_code", 32'(key_code),  32'h0);
        repeat (4) run_scan(16'h0000);

        repeat (4) run_scan(16'h0040);
        chk("pre_rst_keys", 32'(keys_out), 32'h0040);
        keys     = 16'h0040;
        scan_pat = 16'h0040;
        repeat (40) tick();
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clock);
        chk_reset_vals("mid_rst_hold");
        release_reset();
        repeat (4) run_scan(16'h0040);
        chk("post_rst_keys", 32'(keys_out), 32'h0040);
        chk("post_rst_code", 32'(key_code), 32'h6);
        repeat (4) run_scan(16'h0000);

        repeat (4) run_scan(16'h0016);
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("ghost_keys", 32'(keys_out), 32'h0);
        chk("ghost_evt",  32'(key_event), 32'h0);
`else
        chk("ghost_keys", 32'(keys_out), 32'h0016);
        chk("ghost_code", 32'(key_code), 32'h1);
`endif
        run_scan(16'h0016);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
